// File: rtl/systolic_pkg.sv
// Shared state encoding, sequence lengths and operand types for the systolic
// array operand feeder.
package systolic_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_MATRIX_SIZE = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } feeder_state_t;

    typedef logic [DEFAULT_DATA_WIDTH-1:0]                     operand_t;
    typedef logic [DEFAULT_MATRIX_SIZE*DEFAULT_DATA_WIDTH-1:0] row_t;

    function automatic int feed_len(input int n);
        return 3 * n - 2;
    endfunction

    function automatic int drain_len(input int n, input int l);
        return n + l;
    endfunction

endpackage

// File: rtl/systolic_operand_bank.sv
// NxN operand register file: one row write port, N combinational skewed reads
// at time index t (row-diagonal, or column-diagonal when TRANSPOSE is set).
module systolic_operand_bank
    import systolic_pkg::*;
#(
    parameter int N          = 3,
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 2,
    parameter int TW         = 4,
    parameter bit TRANSPOSE  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [N*DATA_WIDTH-1:0] wr_data,
    input  logic [TW-1:0]           t,
    output logic [N*DATA_WIDTH-1:0] diag
);

    logic [DATA_WIDTH-1:0] mem [N][N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else if (wr_en && (int'(wr_addr) < N)) begin
            for (int c = 0; c < N; c++) begin
                mem[wr_addr][c] <= wr_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Port i carries element (t-i) of row i (or of column i when transposed).
    always_comb begin
        diag = '0;
        for (int i = 0; i < N; i++) begin
            if ((int'(t) >= i) && (int'(t) - i < N)) begin
                if (TRANSPOSE) begin
                    diag[i*DATA_WIDTH +: DATA_WIDTH] = mem[AW'(int'(t) - i)][i];
                end else begin
                    diag[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][AW'(int'(t) - i)];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Operand sequencer for the systolic array: buffers A and B, clears the array,
// streams skewed operands, drains the pipeline, then pulses done.
//   state | meaning
//   IDLE  | banks writable, waiting for start
//   CLEAR | one-cycle accumulator clear
//   FEED  | skewed operand streaming, t = 0..3N-3
//   DRAIN | zero operands while the last products propagate
//   DONE  | one-cycle completion pulse
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int PE_LATENCY  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    output logic                              wr_ready,
    input  logic                              wr_sel,
    input  logic [$clog2(MATRIX_SIZE)-1:0]    wr_addr,
    input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] wr_data,
    input  logic                              start,
    input  logic                              hold,
    output logic [MATRIX_SIZE*DATA_WIDTH-1:0] left_o,
    output logic [MATRIX_SIZE*DATA_WIDTH-1:0] top_o,
    output logic                              array_en,
    output logic                              array_clr,
    output logic                              busy,
    output logic                              done
);

    localparam int N  = MATRIX_SIZE;
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(3 * N + PE_LATENCY + 1);
    localparam logic [CW-1:0] FEED_LAST  = CW'(feed_len(N) - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(drain_len(N, PE_LATENCY) - 1);

    feeder_state_t           state, state_next;
    logic [CW-1:0]           t, t_next;
    logic [CW-1:0]           drain_cnt, drain_next;
    logic [CW-1:0]           rd_t;
    logic [N*DATA_WIDTH-1:0] diag_a, diag_b, left_next, top_next;
    logic                    en_next, clr_next, done_next;
    logic                    wr_a, wr_b;

    assign wr_a = wr_en && (state == ST_IDLE) && !wr_sel;
    assign wr_b = wr_en && (state == ST_IDLE) && wr_sel;

    // Banks are read one step ahead so the registered outputs show t.
    assign rd_t = (state == ST_FEED) ? t + CW'(1) : '0;

    systolic_operand_bank #(
        .N(N), .DATA_WIDTH(DATA_WIDTH), .AW(AW), .TW(CW), .TRANSPOSE(1'b0)
    ) bank_a (
        .clk(clk), .rst(rst), .wr_en(wr_a), .wr_addr(wr_addr),
        .wr_data(wr_data), .t(rd_t), .diag(diag_a)
    );

    systolic_operand_bank #(
        .N(N), .DATA_WIDTH(DATA_WIDTH), .AW(AW), .TW(CW), .TRANSPOSE(1'b1)
    ) bank_b (
        .clk(clk), .rst(rst), .wr_en(wr_b), .wr_addr(wr_addr),
        .wr_data(wr_data), .t(rd_t), .diag(diag_b)
    );

    always_comb begin
        state_next = state;
        t_next     = t;
        drain_next = drain_cnt;
        left_next  = left_o;
        top_next   = top_o;
        en_next    = 1'b0;
        clr_next   = 1'b0;
        done_next  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CLEAR;
                    clr_next   = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_next = ST_FEED;
                t_next     = '0;
                left_next  = diag_a;
                top_next   = diag_b;
                en_next    = 1'b1;
            end
            ST_FEED: begin
                if (!hold) begin
                    en_next = 1'b1;
                    if (t == FEED_LAST) begin
                        state_next = ST_DRAIN;
                        drain_next = DRAIN_LAST;
                        left_next  = '0;
                        top_next   = '0;
                    end else begin
                        t_next    = t + CW'(1);
                        left_next = diag_a;
                        top_next  = diag_b;
                    end
                end
            end
            ST_DRAIN: begin
                if (!hold) begin
                    if (drain_cnt == '0) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end else begin
                        drain_next = drain_cnt - CW'(1);
                        en_next    = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            t         <= '0;
            drain_cnt <= '0;
            left_o    <= '0;
            top_o     <= '0;
            array_en  <= 1'b0;
            array_clr <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_ready  <= 1'b1;
        end else begin
            state     <= state_next;
            t         <= t_next;
            drain_cnt <= drain_next;
            left_o    <= left_next;
            top_o     <= top_next;
            array_en  <= en_next;
            array_clr <= clr_next;
            busy      <= (state_next != ST_IDLE);
            done      <= done_next;
            wr_ready  <= (state_next == ST_IDLE);
        end
    end

endmodule
